msadc_integ_ctrl: RTL and testbench

//  Downstream of the runup/zero/start timing generator in the multi-slope converter.
//  - During runup, drives the +/- reference switches from the comparator on every clock.
//  - Counts the reference injections, times the coarse rundown and emits one signed result
//    per conversion on a one-cycle valid strobe.
//  - Owns every integrator switch drive except the zero switch, which the timing generator drives.

---
 rtl/msadc_pkg.sv | 44 ++++
 rtl/msadc_comp_sync.sv | 34 +++
 rtl/msadc_integ_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_msadc_integ_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/msadc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msadc_pkg                                                     |
// | Purpose  : Shared types and default constants for the multi-slope ADC    |
// |            integrator controller: FSM state encoding, switch-drive       |
// |            bundle, default counter/result widths and reference weights.  |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package msadc_pkg;

  // Controller states. FINE is only reachable in the fine-rundown build.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNUP   = 3'd1,
    ST_RUNDOWN = 3'd2,
    ST_FINE    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Integrator switch drives, kept together so every update sets all four
  // at once and mutual exclusion follows from the constants below.
  typedef struct packed {
    logic ref_pos;
    logic ref_neg;
    logic fine_pos;
    logic fine_neg;
  } sw_t;

  localparam sw_t SW_OFF  = '{ref_pos: 1'b0, ref_neg: 1'b0, fine_pos: 1'b0, fine_neg: 1'b0};
  localparam sw_t SW_POS  = '{ref_pos: 1'b1, ref_neg: 1'b0, fine_pos: 1'b0, fine_neg: 1'b0};
  localparam sw_t SW_NEG  = '{ref_pos: 1'b0, ref_neg: 1'b1, fine_pos: 1'b0, fine_neg: 1'b0};
  localparam sw_t SW_FPOS = '{ref_pos: 1'b0, ref_neg: 1'b0, fine_pos: 1'b1, fine_neg: 1'b0};
  localparam sw_t SW_FNEG = '{ref_pos: 1'b0, ref_neg: 1'b0, fine_pos: 1'b0, fine_neg: 1'b1};

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_RD_W       = 12;
  localparam int DEF_RD_MAX     = 4000;
  localparam int DEF_RES_W      = 32;
  localparam int DEF_RUNUP_W    = 64;
  localparam int DEF_FINE_RATIO = 16;

endpackage
`default_nettype wire

// File: rtl/msadc_comp_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msadc_comp_sync                                               |
// | Purpose  : Two-flop synchronizer for the asynchronous comparator output. |
// | Ports    : clk1ms  in  system clock                                      |
// |            rst     in  synchronous reset, active-high (flops clear to 0) |
// |            comp    in  asynchronous comparator output                    |
// |            comp_s  out synchronized comparator, 2 clocks of latency      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module msadc_comp_sync (
  input  logic clk1ms,
  input  logic rst,
  input  logic comp,
  output logic comp_s
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk1ms) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= comp;
      r_sync <= r_meta;
    end
  end

  assign comp_s = r_sync;

endmodule
`default_nettype wire

// File: rtl/msadc_integ_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msadc_integ_ctrl                                              |
// | Purpose  : Multi-slope ADC integrator controller. Drives the reference   |
// |            switches during runup from the comparator, times the coarse   |
// |            (and optionally fine) rundown and emits one signed result per |
// |            conversion with a one-cycle valid strobe.                     |
// | Ports    : clk1ms        in  system clock                                |
// |            rst           in  synchronous reset, active-high              |
// |            start         in  1-cycle conversion start pulse              |
// |            runup         in  runup window                                |
// |            zero          in  integrator zeroing window (abort)           |
// |            comp          in  async comparator (1 = integrator positive)  |
// |            ref_pos/neg   out coarse reference switches (registered)      |
// |            fine_pos/neg  out fine reference switches (registered)        |
// |            result        out signed result, held until next valid        |
// |            result_valid  out 1-cycle strobe with result update           |
// |            overrange     out rundown reached RD_MAX this conversion      |
// |            aborted       out 1-cycle strobe on zero/start abort          |
// | Config   : MSADC_FINE_RUNDOWN_EN enables the fine rundown phase; when    |
// |            undefined, fine switches stay 0 and result is the coarse one. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module msadc_integ_ctrl
  import msadc_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RD_W    = DEF_RD_W,
  parameter int RD_MAX  = DEF_RD_MAX,
  parameter int RUNUP_W = DEF_RUNUP_W,
  parameter int RES_W   = DEF_RES_W
`ifdef MSADC_FINE_RUNDOWN_EN
  ,
  parameter int FINE_RATIO = DEF_FINE_RATIO
`endif
) (
  input  logic                    clk1ms,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    runup,
  input  logic                    zero,
  input  logic                    comp,
  output logic                    ref_pos,
  output logic                    ref_neg,
  output logic                    fine_pos,
  output logic                    fine_neg,
  output logic signed [RES_W-1:0] result,
  output logic                    result_valid,
  output logic                    overrange,
  output logic                    aborted
);

  localparam logic signed [RES_W-1:0] RUNUP_W_S = RES_W'(RUNUP_W);
`ifdef MSADC_FINE_RUNDOWN_EN
  localparam int                      FINE_W       = $clog2(FINE_RATIO);
  localparam logic signed [RES_W-1:0] FINE_RATIO_S = RES_W'(FINE_RATIO);
`endif

  logic w_comp_s;

  state_t                    r_state;
  sw_t                       r_sw;
  logic [CNT_W-1:0]          r_pos_cnt;
  logic [CNT_W-1:0]          r_neg_cnt;
  logic [RD_W-1:0]           r_rd_cnt;
  logic                      r_p;          // comparator polarity at end of runup
  logic                      r_seen_runup; // runup window has opened this conversion
  logic signed [RES_W-1:0]   r_result;
  logic                      r_result_valid;
  logic                      r_overrange;
  logic                      r_aborted;
`ifdef MSADC_FINE_RUNDOWN_EN
  logic [FINE_W-1:0]         r_fine_cnt;
`endif

  msadc_comp_sync u_comp_sync (
    .clk1ms (clk1ms),
    .rst    (rst),
    .comp   (comp),
    .comp_s (w_comp_s)
  );

  // Result datapath: counters are unsigned magnitudes, zero-extended into the
  // signed result width before any arithmetic so no term wraps.
  logic signed [RES_W-1:0] w_neg_ext;
  logic signed [RES_W-1:0] w_pos_ext;
  logic signed [RES_W-1:0] w_rd_ext;
  logic signed [RES_W-1:0] w_coarse;
  logic signed [RES_W-1:0] w_result;

  assign w_neg_ext = $signed({{(RES_W-CNT_W){1'b0}}, r_neg_cnt});
  assign w_pos_ext = $signed({{(RES_W-CNT_W){1'b0}}, r_pos_cnt});
  assign w_rd_ext  = $signed({{(RES_W-RD_W){1'b0}}, r_rd_cnt});
  assign w_coarse  = (w_neg_ext - w_pos_ext) * RUNUP_W_S + (r_p ? w_rd_ext : -w_rd_ext);

`ifdef MSADC_FINE_RUNDOWN_EN
  logic signed [RES_W-1:0] w_fine_ext;
  assign w_fine_ext = $signed({{(RES_W-FINE_W){1'b0}}, r_fine_cnt});
  // Fine reference runs opposite to the coarse rundown, hence the sign flip.
  assign w_result   = w_coarse * FINE_RATIO_S + (r_p ? -w_fine_ext : w_fine_ext);
`else
  assign w_result   = w_coarse;
`endif

  always_ff @(posedge clk1ms) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_sw           <= SW_OFF;
      r_pos_cnt      <= '0;
      r_neg_cnt      <= '0;
      r_rd_cnt       <= '0;
      r_p            <= 1'b0;
      r_seen_runup   <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrange    <= 1'b0;
      r_aborted      <= 1'b0;
`ifdef MSADC_FINE_RUNDOWN_EN
      r_fine_cnt     <= '0;
`endif
    end else begin
      r_result_valid <= 1'b0;
      r_aborted      <= 1'b0;

      if (start) begin
        // A start outside IDLE kills the conversion in flight and restarts.
        r_aborted    <= (r_state != ST_IDLE);
        r_state      <= ST_RUNUP;
        r_sw         <= SW_OFF;
        r_pos_cnt    <= '0;
        r_neg_cnt    <= '0;
        r_rd_cnt     <= '0;
        r_seen_runup <= 1'b0;
        r_overrange  <= 1'b0;
`ifdef MSADC_FINE_RUNDOWN_EN
        r_fine_cnt   <= '0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sw <= SW_OFF;
          end

          ST_RUNUP: begin
            if (zero) begin
              r_sw      <= SW_OFF;
              r_aborted <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (runup) begin
              r_seen_runup <= 1'b1;
              // Push the integrator back toward zero each clock.
              if (w_comp_s) begin
                r_sw <= SW_NEG;
                if (r_neg_cnt != '1) r_neg_cnt <= r_neg_cnt + CNT_W'(1);
              end else begin
                r_sw <= SW_POS;
                if (r_pos_cnt != '1) r_pos_cnt <= r_pos_cnt + CNT_W'(1);
              end
            end else begin
              r_sw <= SW_OFF;
              if (r_seen_runup) begin
                r_p     <= w_comp_s;
                r_state <= ST_RUNDOWN;
              end
            end
          end

          ST_RUNDOWN: begin
            if (zero) begin
              r_sw      <= SW_OFF;
              r_aborted <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (w_comp_s != r_p) begin
              // Zero crossing takes priority over the timeout check.
              r_sw <= SW_OFF;
`ifdef MSADC_FINE_RUNDOWN_EN
              r_state <= ST_FINE;
`else
              r_state <= ST_DONE;
`endif
            end else if (r_rd_cnt == RD_W'(RD_MAX)) begin
              r_sw        <= SW_OFF;
              r_overrange <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_sw     <= r_p ? SW_NEG : SW_POS;
              r_rd_cnt <= r_rd_cnt + RD_W'(1);
            end
          end

`ifdef MSADC_FINE_RUNDOWN_EN
          ST_FINE: begin
            // Fine polarity q is the comparator after the crossing, i.e. !p.
            if (zero) begin
              r_sw      <= SW_OFF;
              r_aborted <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (w_comp_s == r_p) begin
              r_sw    <= SW_OFF;
              r_state <= ST_DONE;
            end else if (r_fine_cnt == FINE_W'(FINE_RATIO - 1)) begin
              r_sw    <= SW_OFF;
              r_state <= ST_DONE;
            end else begin
              r_sw       <= r_p ? SW_FPOS : SW_FNEG;
              r_fine_cnt <= r_fine_cnt + FINE_W'(1);
            end
          end
`endif

          ST_DONE: begin
            // zero is ignored here; the finished conversion still reports.
            r_sw           <= SW_OFF;
            r_result       <= w_result;
            r_result_valid <= 1'b1;
            r_state        <= ST_IDLE;
          end

          default: begin
            r_sw    <= SW_OFF;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ref_pos      = r_sw.ref_pos;
  assign ref_neg      = r_sw.ref_neg;
  assign fine_pos     = r_sw.fine_pos;
  assign fine_neg     = r_sw.fine_neg;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overrange    = r_overrange;
  assign aborted      = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_msadc_integ_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_msadc_integ_ctrl                                           |
// | Purpose  : Self-checking bench for msadc_integ_ctrl. Conversions are     |
// |            described as records; comparator values are driven two       |
// |            clocks ahead so the synchronized comparator lands on the      |
// |            intended cycle. Honours MSADC_FINE_RUNDOWN_EN.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_msadc_integ_ctrl;

  logic        clk1ms = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        runup  = 1'b0;
  logic        zero   = 1'b0;
  logic        comp   = 1'b0;
  logic        ref_pos, ref_neg, fine_pos, fine_neg;
  logic [31:0] result;
  logic        result_valid, overrange, aborted;

  int total = 0;
  int bad   = 0;
  int mutex_viol = 0;

  always #5 clk1ms = ~clk1ms;

  msadc_integ_ctrl dut (
    .clk1ms       (clk1ms),
    .rst          (rst),
    .start        (start),
    .runup        (runup),
    .zero         (zero),
    .comp         (comp),
    .ref_pos      (ref_pos),
    .ref_neg      (ref_neg),
    .fine_pos     (fine_pos),
    .fine_neg     (fine_neg),
    .result       (result),
    .result_valid (result_valid),
    .overrange    (overrange),
    .aborted      (aborted)
  );

  // One conversion: runup length, runup comparator pattern (alternating 1/0
  // or constant), rundown polarity p, clocks before the coarse crossing,
  // clocks before the fine crossing, and hand-computed expectations.
  typedef struct {
    int n_runup; bit alt; bit cval; bit p; int n_rd; int n_fine;
    int exp_res; int exp_res_fine; bit exp_ovr;
    int exp_rpos; int exp_rneg; int exp_fpos; int exp_fneg;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1ms);
    #1;
  endtask

  // Intended synchronized comparator value during cycle c (cycle 0 = start).
  function automatic logic des(input vec_t v, input int c);
    int x;
    x = v.n_runup + 2 + v.n_rd;  // coarse crossing cycle
    if (c >= 1 && c <= v.n_runup) return v.alt ? ((c % 2 == 1) ? 1'b1 : 1'b0) : v.cval;
    else if (c < x)               return v.p;
    else if (c <= x + v.n_fine)   return ~v.p;
    else                          return v.p;
  endfunction

  always @(negedge clk1ms) begin
    if (!rst) begin
      if ((ref_pos && ref_neg) || (fine_pos && fine_neg) ||
          ((ref_pos || ref_neg) && (fine_pos || fine_neg)))
        mutex_viol++;
    end
  end

  task automatic run_conv(input vec_t v, input int exp_abort, input string tag);
    int rv, ab, rpos, rneg, fpos, fneg, res, ovr, limit, done_at, rd_lim;
    rv = 0; ab = 0; rpos = 0; rneg = 0; fpos = 0; fneg = 0; res = 0; ovr = 0; done_at = -1;
    rd_lim = (v.n_rd > 4001) ? 4001 : v.n_rd;
    limit  = v.n_runup + rd_lim + v.n_fine + 30;
    start = 1'b0; runup = 1'b0; zero = 1'b0;
    comp = des(v, 0); step();
    comp = des(v, 1); step();
    for (int c = 0; c <= limit; c++) begin
      if (c >= 1) begin
        rpos += int'(ref_pos); rneg += int'(ref_neg);
        fpos += int'(fine_pos); fneg += int'(fine_neg);
        ab   += int'(aborted);
        if (result_valid) begin
          rv++;
          res = int'($signed(result));
          ovr = int'(overrange);
          if (done_at < 0) done_at = c;
        end
        if (done_at >= 0 && c >= done_at + 3) break;
      end
      start = (c == 0);
      runup = (c >= 1 && c <= v.n_runup);
      comp  = des(v, c + 2);
      step();
    end
    start = 1'b0; runup = 1'b0;
    check({tag, ".valid_count"}, rv, 1);
`ifdef MSADC_FINE_RUNDOWN_EN
    check({tag, ".result"}, res, v.exp_res_fine);
    check({tag, ".fine_pos_clks"}, fpos, v.exp_fpos);
    check({tag, ".fine_neg_clks"}, fneg, v.exp_fneg);
`else
    check({tag, ".result"}, res, v.exp_res);
    check({tag, ".fine_clks"}, fpos + fneg, 0);
`endif
    check({tag, ".overrange"}, ovr, int'(v.exp_ovr));
    check({tag, ".ref_pos_clks"}, rpos, v.exp_rpos);
    check({tag, ".ref_neg_clks"}, rneg, v.exp_rneg);
    check({tag, ".aborted"}, ab, exp_abort);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ref_pos"}, int'(ref_pos), 0);
    check({tag, ".ref_neg"}, int'(ref_neg), 0);
    check({tag, ".fine"}, int'(fine_pos) + int'(fine_neg), 0);
    check({tag, ".result"}, int'($signed(result)), 0);
    check({tag, ".result_valid"}, int'(result_valid), 0);
    check({tag, ".overrange"}, int'(overrange), 0);
    check({tag, ".aborted"}, int'(aborted), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int last_res, rv_cnt, act_cnt;
    vec_t vc;
    //           runup alt cval p  n_rd  fine  res    res_fine ovr rpos  rneg  fpos fneg
    vecs[0] = '{ 40,   1,  0,   1, 7,    3,    7,     109,     0,  20,   27,   3,   0 };
    vecs[1] = '{ 20,   0,  1,   1, 5000, 0,    5280,  84480,   1,  0,    4020, 0,   0 };
    vecs[2] = '{ 10,   0,  0,   0, 30,   2,    -670,  -10718,  0,  40,   0,    0,   2 };
    vecs[3] = '{ 41,   1,  0,   0, 100,  0,    -36,   -576,    0,  120,  21,   0,   0 };
    vecs[4] = '{ 8,    1,  0,   1, 0,    20,   0,     -15,     0,  4,    4,    15,  0 };
    vecs[5] = '{ 2,    1,  0,   1, 4000, 0,    4000,  64000,   0,  1,    4001, 0,   0 };
    vecs[6] = '{ 2,    1,  0,   0, 4001, 0,    -4000, -64000,  1,  4001, 1,    0,   0 };
    vc      = '{ 6,    0,  1,   1, 5,    0,    389,   6224,    0,  0,    11,   0,   0 };

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Reset asserted in the middle of runup.
    comp = 1'b1;
    repeat (3) step();
    start = 1'b1; step();
    start = 1'b0; runup = 1'b1;
    repeat (5) step();
    check("midrunup.ref_neg_active", int'(ref_neg), 1);
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("midrunup_reset");
    runup = 1'b0; comp = 1'b0;
    rst = 1'b0;
    step();

    // Table of complete conversions.
    foreach (vecs[i]) run_conv(vecs[i], 0, $sformatf("vec%0d", i));

`ifdef MSADC_FINE_RUNDOWN_EN
    last_res = vecs[6].exp_res_fine;
`else
    last_res = vecs[6].exp_res;
`endif

    // zero during the 10th runup clock aborts without a result.
    comp = 1'b1;
    repeat (3) step();
    start = 1'b1; step();
    start = 1'b0; runup = 1'b1;
    repeat (9) step();
    check("zero_abort.ref_neg_before", int'(ref_neg), 1);
    zero = 1'b1; step();
    zero = 1'b0;
    check("zero_abort.ref_neg_off", int'(ref_neg), 0);
    check("zero_abort.ref_pos_off", int'(ref_pos), 0);
    check("zero_abort.aborted", int'(aborted), 1);
    step();
    check("zero_abort.aborted_pulse", int'(aborted), 0);
    rv_cnt = 0; act_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) runup = 1'b0;
      rv_cnt  += int'(result_valid);
      act_cnt += int'(ref_pos) + int'(ref_neg);
      step();
    end
    check("zero_abort.no_valid", rv_cnt, 0);
    check("zero_abort.switches_idle", act_cnt, 0);
    check("zero_abort.result_held", int'($signed(result)), last_res);

    // start during rundown aborts and begins a fresh conversion.
    comp = 1'b1;
    repeat (3) step();
    start = 1'b1; step();
    start = 1'b0; runup = 1'b1;
    repeat (10) step();
    runup = 1'b0;
    repeat (20) step();
    check("start_abort.in_rundown", int'(ref_neg), 1);
    run_conv(vc, 1, "start_abort");

    check("switch_mutex_violations", mutex_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
